// File: rtl/ring_input_unit.sv
// ring_input_unit: per-port input unit of the ring router.
// Buffers flits in a DEPTH-entry FIFO and checks head/body/tail framing on ingress.
// It shows the FIFO-head head flit to the lookahead stage and rewrites its routing
// field with the next-hop direction that comes back. The current-hop route is
// locked for the rest of the packet.
// Optional macro RING_IU_BYPASS_EN adds a same-cycle path from input to output
// when the FIFO is empty.
module ring_input_unit #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned X_WIDTH    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      in_head,
    input  logic                      in_tail,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_head,
    output logic                      out_tail,
    output logic [2:0]                out_routing,
    output logic [X_WIDTH-1:0]        la_destination,
    output logic [2:0]                la_current_routing,
    input  logic [2:0]                la_next_routing,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      protocol_error
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned RT_LO = X_WIDTH;
    localparam int unsigned RT_HI = X_WIDTH + 2;

    typedef enum logic { IN_IDLE, IN_PACKET } in_state_e;
    typedef enum logic { EG_IDLE, EG_BODY }   eg_state_e;

    typedef struct packed {
        logic                  head;
        logic                  tail;
        logic [DATA_WIDTH-1:0] data;
    } flit_t;

    flit_t               mem_q [DEPTH];
    flit_t               mem_d [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    in_state_e           in_state_q, in_state_d;
    eg_state_e           eg_state_q, eg_state_d;
    logic [2:0]          locked_q, locked_d;
    logic                err_q, err_d;

    logic                in_legal;
    logic                in_hs;
    logic                bypass;
    logic                wr_en;
    logic                rd_fire;
    logic                fifo_rd;
    flit_t               in_flit;
    flit_t               view;
    logic [2:0]          view_rt;

    assign in_flit  = '{head: in_head, tail: in_tail, data: in_data};
    assign in_legal = in_head ? (in_state_q == IN_IDLE) : (in_state_q == IN_PACKET);
    assign in_ready = (count_q < CNT_W'(DEPTH));
    assign in_hs    = in_valid && in_ready;

`ifdef RING_IU_BYPASS_EN
    logic eg_legal_in;
    assign eg_legal_in = in_head ? (eg_state_q == EG_IDLE) : (eg_state_q == EG_BODY);
    assign bypass = (count_q == '0) && in_valid && in_legal && eg_legal_in && out_ready;
`else
    assign bypass = 1'b0;
`endif

    assign view      = bypass ? in_flit : mem_q[rd_ptr_q];
    assign view_rt   = view.data[RT_HI:RT_LO];
    assign out_valid = bypass || (count_q != '0);
    assign wr_en     = in_hs && in_legal && !bypass;
    assign rd_fire   = out_valid && out_ready;
    assign fifo_rd   = rd_fire && !bypass;
    assign count     = count_q;
    assign protocol_error = err_q;

    // Egress view: lookahead fields, head-flit route rewrite, current-hop direction
    always_comb begin
        out_data           = '0;
        out_head           = 1'b0;
        out_tail           = 1'b0;
        out_routing        = 3'b000;
        la_destination     = '0;
        la_current_routing = 3'b000;
        if (out_valid) begin
            out_data = view.data;
            out_head = view.head;
            out_tail = view.tail;
            if (view.head) begin
                la_destination     = view.data[X_WIDTH-1:0];
                la_current_routing = view_rt;
                out_routing        = view_rt;
                // An empty route is malformed; pass it through untouched
                if (view_rt != 3'b000) begin
                    out_data[RT_HI:RT_LO] = la_next_routing;
                end
            end else if (eg_state_q == EG_BODY) begin
                out_routing = locked_q;
            end
        end
    end

    // Next-state: FIFO storage/pointers, framing FSMs, route lock, sticky error
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        in_state_d = in_state_q;
        eg_state_d = eg_state_q;
        locked_d   = locked_q;
        err_d      = err_q;

        if (wr_en) begin
            mem_d[wr_ptr_q] = in_flit;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (fifo_rd) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(wr_en) - CNT_W'(fifo_rd);

        if (in_hs) begin
            if (!in_legal) begin
                err_d = 1'b1;
            end else if (in_head) begin
                in_state_d = in_tail ? IN_IDLE : IN_PACKET;
                if (in_data[RT_HI:RT_LO] == 3'b000) begin
                    err_d = 1'b1;
                end
            end else if (in_tail) begin
                in_state_d = IN_IDLE;
            end
        end

        if (rd_fire) begin
            if (eg_state_q == EG_IDLE) begin
                if (view.head && !view.tail) begin
                    eg_state_d = EG_BODY;
                    locked_d   = view_rt;
                end
            end else if (view.tail) begin
                eg_state_d = EG_IDLE;
                locked_d   = 3'b000;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_state_q <= IN_IDLE;
            eg_state_q <= EG_IDLE;
            locked_q   <= 3'b000;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_state_q <= in_state_d;
            eg_state_q <= eg_state_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
        end
    end

    // FIFO storage; contents are don't-care while unoccupied, so no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_ring_input_unit.sv
// Directed bench for ring_input_unit (DEPTH=4, DATA_WIDTH=32, X_WIDTH=3).
module tb_ring_input_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_head;
    logic        in_tail;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_head;
    logic        out_tail;
    logic [2:0]  out_routing;
    logic [2:0]  la_destination;
    logic [2:0]  la_current_routing;
    logic [2:0]  la_next_routing;
    logic [2:0]  count;
    logic        protocol_error;

    int checks   = 0;
    int failures = 0;

    ring_input_unit #(.DEPTH(4), .DATA_WIDTH(32), .X_WIDTH(3)) dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_data            (in_data),
        .in_head            (in_head),
        .in_tail            (in_tail),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .out_head           (out_head),
        .out_tail           (out_tail),
        .out_routing        (out_routing),
        .la_destination     (la_destination),
        .la_current_routing (la_current_routing),
        .la_next_routing    (la_next_routing),
        .count              (count),
        .protocol_error     (protocol_error)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic h, input logic t, input logic [31:0] d);
        in_valid = v;
        in_head  = h;
        in_tail  = t;
        in_data  = d;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        la_next_routing = 3'b000;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick;
        tick;
        chk("rst_count",     32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready), 32'd1);
        chk("rst_perr",      32'(protocol_error), 32'd0);
        chk("rst_out_data",  out_data, 32'h0);
        rst = 1'b0;
        tick;

        // Single-flit packet, dest=5, route East, next hop West
        la_next_routing = 3'b001;
        drive(1'b1, 1'b1, 1'b1, 32'hAB00_0015);
        #1;
        chk("sf_no_same_cycle", 32'(out_valid), 32'd0);
        tick;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("sf_out_valid", 32'(out_valid), 32'd1);
        chk("sf_count",     32'(count), 32'd1);
        chk("sf_routing",   32'(out_routing), 32'd2);
        chk("sf_la_dest",   32'(la_destination), 32'd5);
        chk("sf_la_cur",    32'(la_current_routing), 32'd2);
        chk("sf_out_data",  out_data, 32'hAB00_000D);
        chk("sf_ht",        32'({out_head, out_tail}), 32'd3);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        #1;
        chk("sf_drained",   32'(out_valid), 32'd0);
        chk("sf_data_zero", out_data, 32'h0);

        // 4-flit packet streamed through, next hop Local
        la_next_routing = 3'b100;
        drive(1'b1, 1'b1, 1'b0, 32'h1234_0013);
        tick;
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'hDEAD_BEE0);
        #1;
        chk("p4_head_data", out_data, 32'h1234_0023);
        chk("p4_head_rt",   32'(out_routing), 32'd2);
        chk("p4_head_flag", 32'(out_head), 32'd1);
        tick;
        drive(1'b1, 1'b0, 1'b0, 32'hCAFE_0007);
        #1;
        chk("p4_b1_data",  out_data, 32'hDEAD_BEE0);
        chk("p4_b1_rt",    32'(out_routing), 32'd2);
        chk("p4_b1_la",    32'(la_destination), 32'd0);
        tick;
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0FFF);
        #1;
        chk("p4_b2_data",  out_data, 32'hCAFE_0007);
        chk("p4_b2_rt",    32'(out_routing), 32'd2);
        tick;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("p4_tail_data", out_data, 32'h0000_0FFF);
        chk("p4_tail_flag", 32'(out_tail), 32'd1);
        chk("p4_tail_rt",   32'(out_routing), 32'd2);
        tick;
        out_ready = 1'b0;
        #1;
        chk("p4_empty",     32'(out_valid), 32'd0);
        chk("p4_rt_clear",  32'(out_routing), 32'd0);
        chk("p4_perr",      32'(protocol_error), 32'd0);

        // Fill to DEPTH with out_ready low
        la_next_routing = 3'b010;
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0011);
        tick;
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0001);
        tick;
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0002);
        tick;
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0003);
        tick;
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0044);
        #1;
        chk("fill_count",    32'(count), 32'd4);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        tick;
        chk("fill_held_off", 32'(count), 32'd4);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        #1;
        chk("pop_count",    32'(count), 32'd3);
        chk("pop_in_ready", 32'(in_ready), 32'd1);
        chk("pop_next",     out_data, 32'h0000_0001);
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0005);
        tick;
        chk("pushpop_count", 32'(count), 32'd3);
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0006);
        tick;
        chk("pushpop_count2", 32'(count), 32'd3);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick;
        tick;
        chk("drain_last", out_data, 32'h0000_0006);
        chk("drain_last_rt", 32'(out_routing), 32'd2);
        tick;
        out_ready = 1'b0;
        #1;
        chk("drain_count", 32'(count), 32'd0);

        // Body flit while ingress idle: dropped, sticky error
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0077);
        #1;
        chk("bad_in_ready", 32'(in_ready), 32'd1);
        tick;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("bad_count", 32'(count), 32'd0);
        chk("bad_perr",  32'(protocol_error), 32'd1);
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0015);
        tick;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        #1;
        chk("perr_sticky", 32'(protocol_error), 32'd1);
        chk("perr_count",  32'(count), 32'd0);

        // Reset in the middle of a 3-flit packet
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0012);
        tick;
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0009);
        tick;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        chk("mid_count", 32'(count), 32'd2);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mrst_count", 32'(count), 32'd0);
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_perr",  32'(protocol_error), 32'd0);
        chk("mrst_ready", 32'(in_ready), 32'd1);
        la_next_routing = 3'b001;
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0015);
        tick;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("fresh_count", 32'(count), 32'd1);
        chk("fresh_head",  32'(out_head), 32'd1);
        chk("fresh_data",  out_data, 32'h0000_000D);
        chk("fresh_perr",  32'(protocol_error), 32'd0);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;

        // Head with empty route: forwarded unchanged, error raised
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0042);
        tick;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("zrt_data", out_data, 32'h0000_0042);
        chk("zrt_rt",   32'(out_routing), 32'd0);
        chk("zrt_perr", 32'(protocol_error), 32'd1);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        #1;
        chk("zrt_empty", 32'(count), 32'd0);

        // Empty FIFO, consumer ready: bypass or one-cycle latency
        out_ready = 1'b1;
        la_next_routing = 3'b001;
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0015);
        #1;
`ifdef RING_IU_BYPASS_EN
        chk("byp_valid", 32'(out_valid), 32'd1);
        chk("byp_data",  out_data, 32'h0000_000D);
        tick;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("byp_count", 32'(count), 32'd0);
`else
        chk("nobyp_valid", 32'(out_valid), 32'd0);
        tick;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("nobyp_count", 32'(count), 32'd1);
        chk("nobyp_data",  out_data, 32'h0000_000D);
`endif
        tick;
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
